// File: rtl/dnn_param_mem_fix_if.sv
// Load/read bus between the host loader, the inference engine and the parameter memory.
// The memory side takes the slave modport.
interface dnn_param_mem_fix_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int PACK       = 4
);
    logic                           load_start;
    logic [ADDR_WIDTH-1:0]          load_base;
    logic [ADDR_WIDTH-1:0]          load_count;
    logic                           ld_valid;
    logic [DATA_WIDTH*PACK-1:0]     ld_data;
    logic                           ld_ready;
    logic                           loading;
    logic                           load_done;
    logic                           oob_err;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic signed [DATA_WIDTH-1:0]   mem_data;

    modport master (
        output load_start, load_base, load_count, ld_valid, ld_data, mem_addr,
        input  ld_ready, loading, load_done, oob_err, mem_data
    );

    modport slave (
        input  load_start, load_base, load_count, ld_valid, ld_data, mem_addr,
        output ld_ready, loading, load_done, oob_err, mem_data
    );
endinterface

// File: rtl/dnn_param_mem_fix.sv
// Parameter/activation memory: packed streaming loader writing one lane per cycle,
// plus an unconditional one-cycle-latency, read-first engine read port.
module dnn_param_mem_fix #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 16384,
    parameter int PACK       = 4
) (
    input  logic                clk,
    input  logic                rst,
    dnn_param_mem_fix_if.slave  bus
);
    localparam int WORD_W = DATA_WIDTH * PACK;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(PACK - 1);

    typedef enum logic {S_IDLE, S_LOAD} state_e;

    state_e                       state_q, state_d;
    logic                         buf_full_q, buf_full_d;
    logic                         load_done_q, load_done_d;
    logic                         oob_err_q, oob_err_d;
    logic signed [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]        remaining_q, remaining_d;
    logic [WORD_W-1:0]            buf_q, buf_d;
    logic [LANE_W-1:0]            lane_q, lane_d;

    logic                         ld_ready;
    logic                         accept;
    logic                         wr_en;
    logic                         wr_in_range;
    logic                         rd_in_range;
    logic signed [DATA_WIDTH-1:0] wr_elem;

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // A new word may land while the last lane is written, unless that lane ends the load.
    assign ld_ready = (state_q == S_LOAD) &&
                      (!buf_full_q || (lane_q == LAST_LANE && remaining_q > ADDR_WIDTH'(1)));
    assign accept      = bus.ld_valid && ld_ready;
    assign wr_in_range = {1'b0, wr_ptr_q} < DEPTH_X;
    assign rd_in_range = {1'b0, bus.mem_addr} < DEPTH_X;
    assign wr_elem     = buf_q[lane_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        buf_full_d  = buf_full_q;
        load_done_d = 1'b0;
        oob_err_d   = oob_err_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        lane_d      = lane_q;
        wr_en       = 1'b0;
        mem_data_d  = '0;

        if (rd_in_range) begin
            mem_data_d = mem[bus.mem_addr[IDX_W-1:0]];
        end else begin
            oob_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    if (bus.load_count == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        state_d     = S_LOAD;
                        wr_ptr_d    = bus.load_base;
                        remaining_d = bus.load_count;
                        buf_full_d  = 1'b0;
                        lane_d      = '0;
                    end
                end
            end
            S_LOAD: begin
                if (buf_full_q) begin
                    wr_en       = wr_in_range;
                    oob_err_d   = oob_err_d | !wr_in_range;
                    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    if (remaining_q == ADDR_WIDTH'(1)) begin
                        state_d     = S_IDLE;
                        buf_full_d  = 1'b0;
                        lane_d      = '0;
                        load_done_d = 1'b1;
                    end else if (lane_q == LAST_LANE) begin
                        lane_d     = '0;
                        buf_full_d = accept;
                        if (accept) buf_d = bus.ld_data;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end else if (accept) begin
                    buf_d      = bus.ld_data;
                    buf_full_d = 1'b1;
                    lane_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            buf_full_q  <= 1'b0;
            load_done_q <= 1'b0;
            oob_err_q   <= 1'b0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            load_done_q <= load_done_d;
            oob_err_q   <= oob_err_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Datapath registers are qualified by the control state and need no reset.
    always_ff @(posedge clk) begin
        wr_ptr_q    <= wr_ptr_d;
        remaining_q <= remaining_d;
        buf_q       <= buf_d;
        lane_q      <= lane_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[IDX_W-1:0]] <= wr_elem;
    end

    assign bus.ld_ready  = ld_ready;
    assign bus.loading   = (state_q == S_LOAD);
    assign bus.load_done = load_done_q;
    assign bus.oob_err   = oob_err_q;
    assign bus.mem_data  = mem_data_q;
endmodule

// File: tb/tb_dnn_param_mem_fix.sv
// Scoreboard bench for dnn_param_mem_fix: loads driven after each rising edge,
// read results queued at issue and compared on the falling edge after the DUT registers them.
module tb_dnn_param_mem_fix;
    localparam int DW    = 4;
    localparam int AW    = 16;
    localparam int DEPTH = 16384;
    localparam int PACK  = 4;

    typedef struct {
        int addr;
        int exp;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   acc_base;
    bit   rd_vld = 1'b0;
    bit   rd_due = 1'b0;
    rd_t  exp_q[$];
    logic [15:0] wq[$];

    int basic_exp [8] = '{4, 5, 6, 7, 0, 1, -2, -1};
    int part_exp  [6] = '{0, 1, 2, 3, 2, 3};
    int stall_exp [8] = '{4, 3, 2, 1, -5, -6, -7, -8};

    dnn_param_mem_fix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACK(PACK)) bus ();

    dnn_param_mem_fix #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .PACK(PACK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rd_due) begin
            chk("rd_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                rd_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_%0h", e.addr), bus.mem_data, e.exp);
            end
        end
        rd_due = rd_vld;
        if (bus.ld_valid && bus.ld_ready) acc_cnt++;
    end

    task automatic rd(input int a, input int e);
        rd_t t;
        t.addr = a;
        t.exp  = e;
        bus.mem_addr = AW'(a);
        rd_vld = 1'b1;
        exp_q.push_back(t);
        tick();
    endtask

    task automatic rd_end();
        rd_vld = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_load(input int base, input int cnt);
        bus.load_start = 1'b1;
        bus.load_base  = AW'(base);
        bus.load_count = AW'(cnt);
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic stream(input bit stall);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < wq.size() && cyc < 200) begin
            bus.ld_data  = wq[i];
            bus.ld_valid = stall ? cyc[0] : 1'b1;
            acc = bus.ld_valid && bus.ld_ready;
            tick();
            cyc++;
            if (acc) i++;
        end
        bus.ld_valid = 1'b0;
        chk("words_sent", i, wq.size());
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.load_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, bus.load_done, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_count = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.mem_addr   = '0;

        repeat (3) tick();
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_loading", bus.loading, 0);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_oob", bus.oob_err, 0);
        chk("rst_mem_data", bus.mem_data, 0);
        rst = 1'b1;
        tick();

        // Basic load, cycle-exact ready/done behaviour.
        acc_base = acc_cnt;
        start_load(0, 8);
        chk("basic_loading", bus.loading, 1);
        chk("basic_ready0", bus.ld_ready, 1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h7654;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("basic_ready_c%0d", k), bus.ld_ready, (k == 3));
            chk($sformatf("basic_done_c%0d", k), bus.load_done, 0);
            chk($sformatf("basic_loading_c%0d", k), bus.loading, 1);
            if (k == 3) bus.ld_data = 16'hFE10;
            tick();
            if (k == 3) bus.ld_valid = 1'b0;
        end
        chk("basic_done", bus.load_done, 1);
        chk("basic_loading_end", bus.loading, 0);
        chk("basic_ready_end", bus.ld_ready, 0);
        tick();
        chk("basic_done_pulse", bus.load_done, 0);
        chk("basic_words", acc_cnt - acc_base, 2);
        for (int a = 0; a < 8; a++) rd(a, basic_exp[a]);
        rd_end();

        // Sentinel just past the partial load.
        start_load(16'h0197, 1);
        wq = '{16'h0007};
        stream(1'b0);
        wait_done("sentinel_done");

        // Partial final word; a third word offered must not be taken.
        acc_base = acc_cnt;
        start_load(16'h0191, 6);
        wq = '{16'h3210, 16'h5432};
        stream(1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hAAAA;
        wait_done("part_done");
        repeat (3) tick();
        bus.ld_valid = 1'b0;
        chk("part_words", acc_cnt - acc_base, 2);
        for (int a = 0; a < 6; a++) rd(16'h0191 + a, part_exp[a]);
        rd(16'h0197, 7);
        rd_end();

        // Read-first: address 5 holds 1 until lane 0 of the new word lands.
        start_load(5, 1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h000D;
        tick();
        bus.ld_valid = 1'b0;
        rd(5, 1);
        chk("rf_done", bus.load_done, 1);
        rd(5, -3);
        rd_end();

        // Zero-length load.
        start_load(100, 0);
        chk("zero_done", bus.load_done, 1);
        chk("zero_loading", bus.loading, 0);
        chk("zero_ready", bus.ld_ready, 0);
        tick();
        chk("zero_done_pulse", bus.load_done, 0);
        chk("zero_ready2", bus.ld_ready, 0);

        // Stalled vs unstalled load of the same words.
        wq = '{16'h1234, 16'h89AB};
        start_load(16'h0200, 8);
        stream(1'b1);
        wait_done("stall_done");
        start_load(16'h0300, 8);
        stream(1'b0);
        wait_done("nostall_done");
        for (int a = 0; a < 8; a++) rd(16'h0200 + a, stall_exp[a]);
        for (int a = 0; a < 8; a++) rd(16'h0300 + a, stall_exp[a]);
        rd_end();
        chk("oob_clear", bus.oob_err, 0);

        // Load straddling the top of memory.
        start_load(DEPTH - 2, 4);
        wq = '{16'h4321};
        stream(1'b0);
        wait_done("edge_done");
        chk("edge_oob", bus.oob_err, 1);
        rd(DEPTH - 2, 1);
        rd(DEPTH - 1, 2);
        rd_end();

        // Out-of-range read after a fresh reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rdoob_pre", bus.oob_err, 0);
        rd(DEPTH - 1, 2);
        rd(DEPTH, 0);
        rd_end();
        chk("rdoob_flag", bus.oob_err, 1);

        // Abort after three elements.
        bus.mem_addr = '0;
        start_load(16'h0400, 8);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h7531;
        tick();
        bus.ld_valid = 1'b0;
        repeat (3) tick();
        chk("abort_loading_pre", bus.loading, 1);
        chk("abort_data_pre", bus.mem_data, 4);
        rst = 1'b0;
        #1;
        chk("abort_loading", bus.loading, 0);
        chk("abort_ready", bus.ld_ready, 0);
        chk("abort_done", bus.load_done, 0);
        chk("abort_oob", bus.oob_err, 0);
        chk("abort_data", bus.mem_data, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("abort_nodone_%0d", k), bus.load_done, 0);
        end
        chk("abort_idle", bus.loading, 0);
        rd(16'h0400, 1);
        rd(16'h0401, 3);
        rd(16'h0402, 5);
        rd_end();

        chk("rd_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dnn_param_mem_fix.md
# dnn_param_mem_fix

Parameter/activation memory serving the fixed-point DNN inference engine's read port, with a streaming load port for filling it. A host or testbench streams packed 16-bit words of 4-bit signed values into a contiguous address range. The engine then reads one element per cycle through `mem_addr`/`mem_data` with fixed one-cycle latency. It is the responder side of the engine's memory interface, including the loader that writes it.

## Interface
- `DATA_WIDTH`, 4: element width, signed two's complement.
- `ADDR_WIDTH`, 16: address width of both read and load ports.
- `DEPTH`, 16384: number of storage entries; valid addresses 0..DEPTH-1.
- `PACK`, 4: elements per load word; load word width = DATA_WIDTH*PACK.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse; begins a load of `load_count` elements at `load_base`.
- `load_base`  in  ADDR_WIDTH  first write address; sampled with `load_start`.
- `load_count`  in  ADDR_WIDTH  number of elements to write; sampled with `load_start`.
- `ld_valid`  in  1  load word valid.
- `ld_data`  in  DATA_WIDTH*PACK  packed elements; lane 0 = bits [DATA_WIDTH-1:0] → lowest address.
- `ld_ready`  out  1  load word accepted when `ld_valid && ld_ready` at a rising edge.
- `loading`  out  1  high while FSM is in LOAD.
- `load_done`  out  1  one-cycle pulse when the last element is written.
- `oob_err`  out  1  sticky; set by any dropped write or out-of-range read; cleared only by reset.
- `mem_addr`  in  ADDR_WIDTH  engine read address.
- `mem_data`  out  DATA_WIDTH  signed read data, registered.

## Operation
- FSM states: IDLE, LOAD.
  - IDLE → LOAD on `load_start`: latch `wr_ptr = load_base` and `remaining = load_count`.
  - If `load_count` == 0, stay IDLE and pulse `load_done` next cycle.
- LOAD has a one-word unpack buffer and a lane index 0..PACK-1.
  - `ld_ready` = LOAD && (buffer empty || (lane == PACK-1 && remaining > 1)).
  - On acceptance, the word enters the buffer. One lane is written per cycle, lanes in order.
  - Each written lane increments `wr_ptr` and decrements `remaining`.
- When `remaining` reaches 0:
  - Unwritten lanes of the current word are discarded.
  - The buffer is cleared and the FSM returns to IDLE.
  - `load_done` pulses.
- Write to an address ≥ DEPTH: the write is dropped and `oob_err` is set. Pointer and count still advance.
- `wr_ptr` wraps modulo 2^ADDR_WIDTH; no other wrap.
- `load_start` while in LOAD is ignored.
- Read port: every cycle, `mem_data <= mem[mem_addr]`.
  - If `mem_addr` ≥ DEPTH, `mem_data <= 0` and `oob_err` is set.
  - Reads are unconditional; no enable.
- Same-cycle read and write to the same address is read-first: the old value is returned.
- Memory contents are not cleared by reset. Reads of never-written entries are X in simulation and are not checked.

## Timing
- Reset values:
  - Outputs: `ld_ready`=0, `loading`=0, `load_done`=0, `oob_err`=0, `mem_data`=0.
  - Internal: FSM=IDLE, buffer empty.
- Reset asserted mid-load aborts immediately. Entries already written are retained.
- `load_start` sampled at edge T: `loading` and `ld_ready` are high from T+1.
- Word accepted at edge A: lane k is written at edge A+1+k, for k = 0..PACK-1.
- Sustained throughput is 1 word per PACK cycles, back-to-back. `ld_ready` is high in the cycle where lane PACK-1 is being written.
- Last element written at edge E: `load_done` is high for the cycle after E. `loading` and `ld_ready` are low from E onward.
- Read latency: `mem_addr` presented before edge R yields `mem_data` valid after edge R, held until the next edge.
- Gaps in `ld_valid` stall the load only. Reads are never stalled.

## Test plan
- Reset check: assert `rst`=0 mid-operation → all outputs 0 within the same cycle (async), FSM IDLE.
- Basic load: `load_base`=0x0000, `load_count`=8, two words 0x7654 and 0xFE10 streamed back-to-back.
  - Required: addresses 0..7 read back 4,5,6,7,0,1,-2,-1.
  - `load_done` one cycle after the 8th write; `ld_ready` never high while the buffer is non-final.
- Partial final word: `load_base`=0x0191, `load_count`=6, words 0x3210 and 0x5432.
  - Required: 0x0191..0x0196 = 0,1,2,3,2,3.
  - 0x0197 unchanged; exactly 2 words accepted.
- Read latency and read-first: read address 5 while writing address 5 with new value -3.
  - Required: `mem_data` shows the old value the next cycle and -3 one cycle after a repeat read.
- Boundary/errors:
  - `load_base`=DEPTH-2, `load_count`=4 → two writes land, two are dropped, `oob_err`=1.
  - Read `mem_addr`=DEPTH → `mem_data`=0.
  - `load_count`=0 → `load_done` pulse, no `ld_ready`.
- Stall and abort:
  - `ld_valid` toggled every other cycle → final contents identical to an unstalled load.
  - Reset pulsed after 3 elements → `loading`=0, first 3 entries retained, no `load_done`.
